// File: rtl/vm_pkg.sv
// Shared vending-machine types: credit width, coin codes, FSM states.
// Exposes coin_credit() to turn a 2-bit coin code into credit units.
package vm_pkg;

    localparam int AW = 5;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    function automatic logic [AW-1:0] coin_credit(input logic [1:0] code);
        logic [AW-1:0] v;
        v = '0;
        case (code)
            COIN_1:  v = AW'(1);
            COIN_2:  v = AW'(2);
            COIN_5:  v = AW'(5);
            COIN_10: v = AW'(10);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/credit_controller_if.sv
// Coin/buy/cancel/change bundle between the front panel and credit_controller.
// master drives requests and change_ack; slave returns credit and vend status.
interface credit_controller_if;
    import vm_pkg::*;

    logic          coin_valid;
    logic [1:0]    coin_value;
    logic          buy;
    logic          cancel;
    logic          change_ack;
    logic [AW-1:0] current_amount;
    logic          coin_reject;
    logic          insufficient;
    logic          dispense;
    logic          change_valid;
    logic [AW-1:0] change_amount;
    logic          busy;

    modport master (
        output coin_valid, coin_value, buy, cancel, change_ack,
        input  current_amount, coin_reject, insufficient,
        input  dispense, change_valid, change_amount, busy
    );

    modport slave (
        input  coin_valid, coin_value, buy, cancel, change_ack,
        output current_amount, coin_reject, insufficient,
        output dispense, change_valid, change_amount, busy
    );

endinterface

// File: rtl/coin_decoder.sv
// Combinational coin decoder: 2-bit coin code to AW-bit credit value.
// Ports: code (in, 2), value (out, AW).
module coin_decoder
    import vm_pkg::*;
(
    input  logic [1:0]    code,
    output logic [AW-1:0] value
);

    assign value = coin_credit(code);

endmodule

// File: rtl/credit_controller.sv
// Coin accumulation and vend sequencing FSM; all outputs registered.
// Ports: clk, rst_n (async, active-low), bus (credit_controller_if.slave).
module credit_controller
    import vm_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_AMOUNT = 31
) (
    input logic                clk,
    input logic                rst_n,
    credit_controller_if.slave bus
);

    localparam logic [AW-1:0] PRICE_V = AW'(PRICE);
    localparam logic [AW:0]   MAX_V   = (AW+1)'(MAX_AMOUNT);

    state_t        state, state_n;
    logic [AW-1:0] amount, amount_n;
    logic          reject, reject_n;
    logic          insuf, insuf_n;
    logic          disp, disp_n;
    logic          cvalid, cvalid_n;
    logic [AW-1:0] camount, camount_n;
    logic          busy_q, busy_n;

    logic [AW-1:0] coin;
    logic [AW:0]   sum;
    logic [AW-1:0] remainder;

    coin_decoder u_dec (
        .code  (bus.coin_value),
        .value (coin)
    );

    // Extra bit keeps an over-ceiling sum from wrapping.
    assign sum       = {1'b0, amount} + {1'b0, coin};
    assign remainder = amount - PRICE_V;

    always_comb begin
        state_n   = state;
        amount_n  = amount;
        reject_n  = 1'b0;
        insuf_n   = 1'b0;
        cvalid_n  = cvalid;
        camount_n = camount;
        unique case (state)
            IDLE: begin
                if (bus.cancel) begin
                    reject_n = bus.coin_valid;
                    if (amount != '0) begin
                        camount_n = amount;
                        cvalid_n  = 1'b1;
                        state_n   = CHANGE;
                    end
                end else if (bus.buy) begin
                    reject_n = bus.coin_valid;
                    if (amount >= PRICE_V) begin
                        state_n = DISPENSE;
                    end else begin
                        insuf_n = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (sum <= MAX_V) begin
                        amount_n = sum[AW-1:0];
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                reject_n = bus.coin_valid;
                amount_n = remainder;
                if (remainder != '0) begin
                    camount_n = remainder;
                    cvalid_n  = 1'b1;
                    state_n   = CHANGE;
                end else begin
                    state_n = IDLE;
                end
            end
            CHANGE: begin
                reject_n = bus.coin_valid;
                if (bus.change_ack) begin
                    amount_n  = '0;
                    cvalid_n  = 1'b0;
                    camount_n = '0;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Status outputs reflect the state being entered.
        disp_n = (state_n == DISPENSE);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            amount  <= '0;
            reject  <= 1'b0;
            insuf   <= 1'b0;
            disp    <= 1'b0;
            cvalid  <= 1'b0;
            camount <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            amount  <= amount_n;
            reject  <= reject_n;
            insuf   <= insuf_n;
            disp    <= disp_n;
            cvalid  <= cvalid_n;
            camount <= camount_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.current_amount = amount;
    assign bus.coin_reject    = reject;
    assign bus.insufficient   = insuf;
    assign bus.dispense       = disp;
    assign bus.change_valid   = cvalid;
    assign bus.change_amount  = camount;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_credit_controller.sv
// Scoreboard bench for credit_controller: expected outputs are queued per
// driven cycle and popped/compared one time unit after the sampling edge.
module tb_credit_controller;
    import vm_pkg::*;

    typedef struct {
        int amt;
        int rej;
        int ins;
        int disp;
        int cv;
        int ca;
        int busy;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    credit_controller_if bus ();

    credit_controller #(.PRICE(15), .MAX_AMOUNT(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input int amt, input int rej, input int ins,
                        input int disp, input int cv, input int ca,
                        input int busy);
        exp_t e;
        e.amt  = amt;
        e.rej  = rej;
        e.ins  = ins;
        e.disp = disp;
        e.cv   = cv;
        e.ca   = ca;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check({tag, ".sb"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".amt"},  int'(bus.current_amount), e.amt);
            check({tag, ".rej"},  int'(bus.coin_reject),    e.rej);
            check({tag, ".ins"},  int'(bus.insufficient),   e.ins);
            check({tag, ".disp"}, int'(bus.dispense),       e.disp);
            check({tag, ".cv"},   int'(bus.change_valid),   e.cv);
            check({tag, ".ca"},   int'(bus.change_amount),  e.ca);
            check({tag, ".busy"}, int'(bus.busy),           e.busy);
        end
    endtask

    // Drive one cycle of inputs; expected outputs follow that edge.
    // coin < 0 means no coin.
    task automatic cyc(input string tag, input int coin, input bit b,
                       input bit c, input bit ack,
                       input int amt, input int rej, input int ins,
                       input int disp, input int cv, input int ca,
                       input int busy);
        bus.coin_valid = (coin >= 0);
        case (coin)
            1:       bus.coin_value = COIN_1;
            2:       bus.coin_value = COIN_2;
            5:       bus.coin_value = COIN_5;
            10:      bus.coin_value = COIN_10;
            default: bus.coin_value = 2'b00;
        endcase
        bus.buy        = b;
        bus.cancel     = c;
        bus.change_ack = ack;
        push(amt, rej, ins, disp, cv, ca, busy);
        @(posedge clk);
        #1;
        bus.coin_valid = 1'b0;
        bus.coin_value = 2'b00;
        bus.buy        = 1'b0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;
        compare(tag);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_value = 2'b00;
        bus.buy        = 1'b0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        push(0, 0, 0, 0, 0, 0, 0);
        compare("reset");
        rst_n = 1'b1;

        //   tag       coin b  c  ack amt rej ins dsp cv ca bsy
        cyc("c10",     10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("c5",       5, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        cyc("c2",       2, 0, 0, 0, 17, 0, 0, 0, 0, 0, 0);
        cyc("buy17",   -1, 1, 0, 0, 17, 0, 0, 1, 0, 0, 1);
        cyc("chg2",    -1, 0, 0, 0,  2, 0, 0, 0, 1, 2, 1);
        cyc("hold2",   -1, 0, 0, 0,  2, 0, 0, 0, 1, 2, 1);
        cyc("ack2",    -1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

        cyc("s10a",    10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("s10b",    10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0);
        cyc("s5",       5, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0);
        cyc("s2",       2, 0, 0, 0, 27, 0, 0, 0, 0, 0, 0);
        cyc("sat5",     5, 0, 0, 0, 27, 1, 0, 0, 0, 0, 0);
        cyc("s29",      2, 0, 0, 0, 29, 0, 0, 0, 0, 0, 0);
        cyc("s31",      2, 0, 0, 0, 31, 0, 0, 0, 0, 0, 0);
        cyc("sat1",     1, 0, 0, 0, 31, 1, 0, 0, 0, 0, 0);
        cyc("can31",   -1, 0, 1, 0, 31, 0, 0, 0, 1, 31, 1);
        cyc("ack31",   -1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

        cyc("i10",     10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("i12",      2, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc("insuf",   -1, 1, 0, 0, 12, 0, 1, 0, 0, 0, 0);
        cyc("idle12",  -1, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        cyc("can12",   -1, 0, 1, 0, 12, 0, 0, 0, 1, 12, 1);
        cyc("ack12",   -1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

        cyc("e10",     10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("e15",      5, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        cyc("buycoin",  5, 1, 0, 0, 15, 1, 0, 1, 0, 0, 1);
        cyc("exact",   -1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        cyc("t10a",    10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("t20",     10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0);
        cyc("buy20",   -1, 1, 0, 0, 20, 0, 0, 1, 0, 0, 1);
        cyc("chg5",    -1, 0, 0, 0,  5, 0, 0, 0, 1, 5, 1);
        cyc("chgcoin",  1, 0, 0, 0,  5, 1, 0, 0, 1, 5, 1);
        cyc("chgbuy",  -1, 1, 1, 0,  5, 0, 0, 0, 1, 5, 1);
        cyc("ack5",    -1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

        cyc("r10a",    10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc("r20",     10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0);
        cyc("can20",   -1, 0, 1, 0, 20, 0, 0, 0, 1, 20, 1);
        #2;
        rst_n = 1'b0;
        #1;
        push(0, 0, 0, 0, 0, 0, 0);
        compare("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post1",    1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        cyc("ackidle", -1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
        cyc("cancoin",  2, 0, 1, 0,  1, 1, 0, 0, 1, 1, 1);
        cyc("ack1",    -1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        cyc("can0",    -1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/credit_controller.md
Name: credit_controller

Overview:
- Coin-accumulation and vend-sequencing FSM for the vending machine.
- Sits directly upstream of display_controller: its registered current_amount output drives display_controller's current_amount input (5-bit, 0..31).
- Accepts coin pulses, saturation-protects the credit, and handles buy/cancel requests.
- Issues a dispense pulse and a change-return handshake.

Parameters:
- PRICE, 15: product price in credit units; legal range 1..MAX_AMOUNT.
- MAX_AMOUNT, 31: credit ceiling; must fit in 5 bits.
- AW, 5: credit width; fixed to match display_controller.current_amount.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle pulse; a coin is present.
- coin_value  in  2  coin code: 00=1, 01=2, 10=5, 11=10.
- buy  in  1  one-cycle purchase request.
- cancel  in  1  one-cycle refund request.
- change_ack  in  1  change hopper has paid out change_amount.
- current_amount  out  AW  registered credit; feeds display_controller.
- coin_reject  out  1  one-cycle pulse; the coin was refused (returned to user).
- insufficient  out  1  one-cycle pulse; buy was refused because credit < PRICE.
- dispense  out  1  one-cycle pulse; release one product.
- change_valid  out  1  change_amount is valid; held until change_ack.
- change_amount  out  AW  refund value; 0 when change_valid=0.
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
Clocking and reset
- One clock; reset is asynchronous and active-low (clk, rst_n). Polarity and synchronicity are fixed.
- Reset (rst_n=0): state=IDLE. current_amount, coin_reject, insufficient, dispense, change_valid, change_amount and busy are all 0.
- Reset asserted mid-operation aborts immediately. Credit is lost and no change is issued.
- All outputs are registered. Each event's response appears on the cycle after the sampling edge.

Coin decode and arithmetic
- Coin decode: 1/2/5/10, zero-extended to AW+1 bits.
- Sum = current_amount + coin, computed AW+1 wide; no wrap-around is allowed.

States
- IDLE
  - Priority order: cancel > buy > coin.
  - cancel with current_amount>0: change_amount<=current_amount, change_valid<=1, go to CHANGE.
  - cancel with current_amount==0: ignored; stay in IDLE.
  - buy with current_amount>=PRICE: go to DISPENSE.
  - buy with current_amount<PRICE: insufficient pulse; credit unchanged.
  - coin alone, sum<=MAX_AMOUNT: current_amount<=sum.
  - coin alone, sum>MAX_AMOUNT: coin_reject pulse; credit unchanged.
  - coin arriving in the same cycle as buy or cancel: rejected (coin_reject=1).
- DISPENSE (exactly 1 cycle)
  - dispense=1; current_amount<=current_amount-PRICE.
  - Remainder>0: change_amount<=remainder, change_valid<=1, go to CHANGE.
  - Remainder==0: go to IDLE.
- CHANGE
  - change_valid and change_amount are held stable until change_ack.
  - On change_ack: current_amount<=0, change_valid<=0, change_amount<=0, go to IDLE.
- busy=1 in DISPENSE and CHANGE.
  - Any coin in these states is rejected with a coin_reject pulse.
  - buy and cancel are ignored in these states.
- change_ack outside CHANGE is ignored.
- current_amount never exceeds MAX_AMOUNT and never goes negative.

Decomposition:
- Shared package vm_pkg holds:
  - coin code constants COIN_1/2/5/10 and the coin_value-to-credit decode function;
  - state encoding IDLE/DISPENSE/CHANGE;
  - AW.
- Sub-module coin_decoder (combinational, 2-bit code to AW-bit value) is natural; it is reusable by the coin-validator front end.
- FSM and credit register stay in credit_controller.

Test Plan:
- Reset, then coins 10, 5, 2 → current_amount 10, 15, 17 on successive cycles after each pulse; no reject.
- Credit 17, buy → dispense pulse for 1 cycle; then change_valid=1, change_amount=2, busy=1; after change_ack: current_amount=0, back in IDLE.
- Credit 27, coin 5 → coin_reject pulse, credit stays 27. Then coin 2 → credit 29. Then coin 2 → 31. Then coin 1 → reject, credit stays 31.
- Credit 12, buy → insufficient pulse, credit 12, no dispense. cancel → change_amount=12; ack → 0.
- Credit 15 with buy+coin 5 in the same cycle → coin_reject and dispense, change_valid stays 0, credit 0. Coin during CHANGE (after a credit-20 buy) → rejected, change_amount stays 5.
- Credit 20 in CHANGE, assert rst_n=0 asynchronously mid-cycle → all outputs 0 immediately; coin 1 after release → credit 1.
